// File: rtl/fb_lsu.sv
// MEM-stage load/store unit: issues req/ack data-memory transactions and aligns/extends load data.
// Optional bus timeout abort is enabled by defining FB_LSU_TIMEOUT_EN.
module fb_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_store_data,
  output logic [31:0] mem_memory_data,
  output logic        lsu_stall,
  output logic        lsu_misalign,
  output logic        lsu_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fb_lsu: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        access, is_store, legal;
  logic [1:0]  off;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        timeout;

  assign access   = mem_mem_read | mem_mem_write;
  assign is_store = mem_mem_write;
  assign off      = mem_alu_res[1:0];

`ifdef FB_LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout = (state_q == S_ACCESS) && !dmem_ack && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = (state_q == S_ACCESS && !dmem_ack) ? cnt_q + 8'd1 : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    legal = 1'b0;
    case (mem_funct3)
      3'b000:         legal = 1'b1;
      3'b001:         legal = !off[0];
      3'b010:         legal = (off == 2'b00);
      3'b100:         legal = !is_store;
      3'b101:         legal = !is_store && !off[0];
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_store_data;
    case (mem_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        st_be    = off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (access && legal) state_d = S_ACCESS;
      S_ACCESS: if (dmem_ack || timeout) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus registers are loaded on ACCESS entry and cleared on exit, so they stay stable in between.
  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    data_d     = data_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    lsu_stall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && legal) begin
          lsu_stall = 1'b1;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {mem_alu_res[31:2], 2'b00};
          wdata_d   = is_store ? st_wdata : '0;
          be_d      = is_store ? st_be : '0;
          funct3_d  = mem_funct3;
          off_d     = off;
        end else if (access) begin
          misalign_d = 1'b1;
          data_d     = '0;
        end
      end
      S_ACCESS: begin
        lsu_stall = 1'b1;
        if (dmem_ack || timeout) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          if (dmem_ack) begin
            if (!we_q) data_d = ld_ext;
          end else begin
            data_d    = '0;
            bus_err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      data_q     <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_memory_data = data_q;
  assign lsu_misalign    = misalign_q;
  assign lsu_bus_err     = bus_err_q;
  assign dmem_req        = req_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign dmem_be         = be_q;

endmodule
